// File: rtl/conv_scan_ctrl_if.sv
// conv_scan_ctrl_if: control, read-strobe and write-strobe bundle of the scan sequencer.
// The master modport is the sequencer. The slave modport is the filter datapath
// side, which drives start, stall and (optionally) abort.
// Optional: SCAN_ABORT_EN adds the abort request and the aborted status.
interface conv_scan_ctrl_if;
    logic        start;
    logic        stall;
    logic        rd;
    logic [14:0] rd_addr;
    logic [1:0]  rd_bank;
    logic        wr;
    logic [12:0] wr_addr;
    logic [1:0]  wr_bank;
    logic        busy;
    logic        done;
`ifdef SCAN_ABORT_EN
    logic        abort;
    logic        aborted;

    modport master (
        input  start, stall, abort,
        output rd, rd_addr, rd_bank, wr, wr_addr, wr_bank, busy, done, aborted
    );
    modport slave (
        output start, stall, abort,
        input  rd, rd_addr, rd_bank, wr, wr_addr, wr_bank, busy, done, aborted
    );
`else
    modport master (
        input  start, stall,
        output rd, rd_addr, rd_bank, wr, wr_addr, wr_bank, busy, done
    );
    modport slave (
        output start, stall,
        input  rd, rd_addr, rd_bank, wr, wr_addr, wr_bank, busy, done
    );
`endif
endinterface

// File: rtl/conv_scan_ctrl.sv
// conv_scan_ctrl: window-origin scan sequencer for the 3x3 filter memory banks.
// It walks every bank's padded image and issues one read origin per active cycle.
// It replays each read as a write strobe PIPE_LAT active cycles later, then pulses
// done once the last bank is issued and the pipeline has drained.
// rd and wr are qualified by stall in the same cycle, so a held cycle never strobes.
// Optional: define SCAN_ABORT_EN to add the abort input and the aborted status.
module conv_scan_ctrl #(
    parameter int unsigned IMG_W    = 256,
    parameter int unsigned PAD_W    = 258,
    parameter int unsigned ROWS     = 32,
    parameter int unsigned BANKS    = 4,
    parameter int unsigned PIPE_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    conv_scan_ctrl_if.master bus
);
    localparam int unsigned RD_AW  = 15;
    localparam int unsigned WR_AW  = 13;
    localparam int unsigned BANK_W = 2;
    localparam int unsigned COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned PB_W   = BANK_W * PIPE_LAT;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [BANK_W-1:0]   bank_q, bank_d;
    logic [RD_AW-1:0]    base_q, base_d;
    logic [RD_AW-1:0]    rd_addr_q, rd_addr_d;
    logic [PIPE_LAT-1:0] v_q, v_d;
    logic [PB_W-1:0]     b_q, b_d;
    logic [WR_AW-1:0]    wr_addr_q, wr_addr_d;
    logic [BANK_W-1:0]   last_bank_q, last_bank_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [PIPE_LAT:0]      v_chain;
    logic [PB_W+BANK_W-1:0] b_chain;
    logic                   out_v, nxt_v;
    logic [BANK_W-1:0]      out_b, nxt_b, ref_b;
    logic                   rd_c, wr_c, abort_c, active_c;

    assign active_c = (state_q == S_RUN) || (state_q == S_DRAIN);

`ifdef SCAN_ABORT_EN
    logic aborted_q, aborted_d;

    // Abort only has an effect while a frame is in flight.
    assign abort_c = bus.abort && active_c;

    // The aborted status is set together with the abort's done and held until the next start.
    always_comb begin
        aborted_d = aborted_q;
        if ((state_q == S_IDLE) && bus.start) begin
            aborted_d = 1'b0;
        end
        if (abort_c) begin
            aborted_d = 1'b1;
        end
    end

    // Aborted status register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= aborted_d;
        end
    end

    assign bus.aborted = aborted_q;
`else
    assign abort_c = 1'b0;
`endif

    // Next-state logic: the FSM plus the origin walk (col/row/bank and the read address).
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        bank_d    = bank_q;
        base_d    = base_q;
        rd_addr_d = rd_addr_q;
        rd_c      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort_c) begin
                    state_d = S_FIN;
                end else if (!bus.stall) begin
                    rd_c = 1'b1;
                    if (col_q == COL_W'(IMG_W - 1)) begin
                        col_d = '0;
                        if (row_q == ROW_W'(ROWS - 1)) begin
                            row_d     = '0;
                            base_d    = '0;
                            rd_addr_d = '0;
                            if (bank_q == BANK_W'(BANKS - 1)) begin
                                bank_d  = '0;
                                state_d = S_DRAIN;
                            end else begin
                                bank_d = bank_q + BANK_W'(1);
                            end
                        end else begin
                            // Jump to the next row base, skipping the two pad columns.
                            row_d     = row_q + ROW_W'(1);
                            base_d    = base_q + RD_AW'(PAD_W);
                            rd_addr_d = base_q + RD_AW'(PAD_W);
                        end
                    end else begin
                        col_d     = col_q + COL_W'(1);
                        rd_addr_d = rd_addr_q + RD_AW'(1);
                    end
                end
            end
            S_DRAIN: begin
                // Finish once this advance writes the last valid entry.
                if (abort_c) begin
                    state_d = S_FIN;
                end else if (!bus.stall && ((v_q << 1) == '0)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d   = S_IDLE;
                col_d     = '0;
                row_d     = '0;
                bank_d    = '0;
                base_d    = '0;
                rd_addr_d = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_FIN);
    end

    // Latency pipeline of {valid, bank} and write-address tracking.
    always_comb begin
        v_chain = {v_q, rd_c};
        b_chain = {b_q, bank_q};
        out_v   = v_chain[PIPE_LAT];
        out_b   = b_chain[PB_W +: BANK_W];
        nxt_v   = v_chain[PIPE_LAT-1];
        nxt_b   = b_chain[PB_W-BANK_W +: BANK_W];
        ref_b   = out_v ? out_b : last_bank_q;
        wr_c    = out_v && !bus.stall && !abort_c;

        v_d         = v_q;
        b_d         = b_q;
        wr_addr_d   = wr_addr_q;
        last_bank_d = last_bank_q;

        if (wr_c) begin
            wr_addr_d   = wr_addr_q + WR_AW'(1);
            last_bank_d = out_b;
        end
        // The next entry to reach the output belongs to a new bank, so restart its address.
        if (!bus.stall && nxt_v && (nxt_b != ref_b)) begin
            wr_addr_d = '0;
        end
        if (!bus.stall) begin
            v_d = v_chain[PIPE_LAT-1:0];
            b_d = b_chain[PB_W-1:0];
        end
        if (abort_c) begin
            v_d = '0;
        end
        if (state_q == S_FIN) begin
            v_d         = '0;
            wr_addr_d   = '0;
            last_bank_d = '0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            bank_q      <= '0;
            base_q      <= '0;
            rd_addr_q   <= '0;
            v_q         <= '0;
            b_q         <= '0;
            wr_addr_q   <= '0;
            last_bank_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            bank_q      <= bank_d;
            base_q      <= base_d;
            rd_addr_q   <= rd_addr_d;
            v_q         <= v_d;
            b_q         <= b_d;
            wr_addr_q   <= wr_addr_d;
            last_bank_q <= last_bank_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.rd      = rd_c;
    assign bus.rd_addr = rd_addr_q;
    assign bus.rd_bank = bank_q;
    assign bus.wr      = wr_c;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_bank = out_b;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: doc/conv_scan_ctrl.md
Name: conv_scan_ctrl

Overview:
- Sequencer for the 3x3 window-read memory banks and their write-back path in the parallel filter datapath.
- Walks the window origin across each bank's padded image (row pitch PAD_W), issuing one read strobe plus origin address per cycle.
- Generates write strobes and addresses delayed by the filter pipeline latency, then steps to the next bank.
- Signals done when every bank has been scanned and the pipeline has drained.

Parameters:
- IMG_W, 256: output pixels per row, i.e. window origins per row.
- PAD_W, 258: padded row pitch in memory words.
- ROWS, 32: output rows per bank (padded rows minus 2).
- BANKS, 4: number of banks scanned in sequence.
- PIPE_LAT, 2: cycles from rd to the matching filtered pixel being valid for wr (1..8).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; starts a frame when idle.
- stall  in  1  downstream hold; freezes issue and the latency pipeline.
- rd  out  1  window read strobe.
- rd_addr  out  15  window top-left address = row*PAD_W + col.
- rd_bank  out  2  bank being read.
- wr  out  1  write strobe for the filtered pixel.
- wr_addr  out  13  write address within the bank = row*IMG_W + col.
- wr_bank  out  2  bank being written.
- busy  out  1  high from the cycle after start until the done cycle.
- done  out  1  one-cycle pulse when the frame is complete.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; col, row, bank and address counters 0; valid shift register cleared.
- FSM states: IDLE, RUN, DRAIN, FIN.
- IDLE: start=1 -> RUN next cycle; busy=1. start is ignored in every state other than IDLE.
- RUN, stall=0:
  - rd=1 with the current rd_addr/rd_bank.
  - col increments. At col=IMG_W-1: col->0, row+1, and rd_addr jumps to the next row base (base += PAD_W), skipping the 2 pad columns.
  - At row=ROWS-1 and col=IMG_W-1: row->0, bank+1, rd_addr->0.
  - At the last origin of bank BANKS-1 -> DRAIN.
- RUN, stall=1: rd=0; counters, addresses and the pipeline all hold.
- Latency pipeline:
  - PIPE_LAT-deep shift register carrying {valid, bank}; it advances only when stall=0.
  - wr = valid output AND NOT stall. wr_bank comes from the pipeline.
  - wr_addr increments on every wr and resets to 0 when wr_bank changes, wrapping from 8191 to 0.
  - The rd at cycle t produces wr at cycle t+PIPE_LAT when no stall occurs in between.
- DRAIN: rd=0; the pipeline advances while stall=0. When the pipeline is empty -> FIN.
- FIN: done=1 for one cycle, busy=0, FSM -> IDLE, all counters cleared.
- Totals per frame: exactly BANKS*ROWS*IMG_W reads (32768 at defaults) and the same number of writes, exactly IMG_W*ROWS writes per bank, in order.
- Last read address per bank: (ROWS-1)*PAD_W + IMG_W-1 = 8253.
- Reset asserted mid-frame: everything returns to reset values immediately. In-flight pipeline entries are discarded with no wr, and no done is produced.
- start coincident with stall: the frame starts, but the first rd waits for stall=0.

Optional Feature:
- Macro SCAN_ABORT_EN.
- When defined, adds input abort (1 bit).
- abort=1 in RUN or DRAIN: rd is forced to 0 that cycle, issue stops, the pipeline is flushed without wr, then FIN with done=1. A status output aborted (1 bit) is set with that done and cleared on the next start.
- When not defined, there is no abort port and no aborted port, and frames always run to completion.

Test Plan:
- Reset then start pulse, stall=0 held -> first rd on the cycle after RUN entry with rd_addr=0, rd_bank=0; first wr exactly 2 cycles later with wr_addr=0; done after 32768 reads + 2 drain cycles.
- Row wrap: observe the reads at col 255 then col 0 of the next row -> rd_addr goes 255 then 258, and 8253 on the last read of bank 0; the next rd has rd_addr=0, rd_bank=1.
- Stall for 5 cycles mid-row at rd_addr=100 -> no rd or wr during the stall; resumes at rd_addr=101 with wr/rd spacing still 2 active cycles; no pixel lost or duplicated (scoreboard count 32768).
- start pulses during RUN -> ignored, and rd_addr sequence is unchanged.
- Assert rst_n=0 at read 1000 -> all outputs 0 asynchronously; after release and a new start, rd_addr restarts at 0 and no done is seen from the aborted frame.
- With SCAN_ABORT_EN: abort at read 500 -> no further rd, at most PIPE_LAT flushed entries produce no wr, done=1 and aborted=1 one cycle; the next start clears aborted.
